// File: rtl/mini_cpu_core.sv
// Multi-cycle mini CPU core: four data registers, zero flag, external synchronous
// instruction/data memories, conditional branch and single-step debug pause.
module mini_cpu_core #(
  parameter int PC_W = 8,
  parameter int DATA_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [7:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              step_mode,
  input  logic              step_req,
  output logic [2:0]        state_dbg,
  output logic [PC_W-1:0]   pc_dbg,
  output logic [15:0]       ir_dbg,
  output logic              halted,
  output logic              retired
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_HALT    = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg;
  logic [15:0]       ir_reg;
  logic              z_reg;
  logic [DATA_W-1:0] regs [4];

  logic [3:0]        opcode;
  logic [1:0]        rd, rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val, rs_val, alu_res, wr_data;
  logic              is_alu, take_jump, completing, wr_en;

  assign opcode = ir_reg[15:12];
  assign rd     = ir_reg[11:10];
  assign rs     = ir_reg[9:8];
  assign imm    = ir_reg[7:0];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];

  assign is_alu    = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign take_jump = (opcode == OP_JMP) || (opcode == OP_JZ && z_reg);

  // Outputs are decoded from the state register so that an asynchronous reset
  // removes dmem_we and retired immediately.
  assign imem_addr  = pc_reg;
  assign dmem_addr  = imm;
  assign dmem_wdata = rd_val;
  assign dmem_we    = (state_reg == S_EXECUTE) && (opcode == OP_ST);
  assign retired    = ((state_reg == S_EXECUTE) && (opcode != OP_LD)) || (state_reg == S_MEM);
  assign halted     = (state_reg == S_HALT);
  assign state_dbg  = state_reg;
  assign pc_dbg     = pc_reg;
  assign ir_dbg     = ir_reg;

  always_comb begin
    alu_res = rd_val;
    case (opcode)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      default: alu_res = rd_val;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = alu_res;
    if (state_reg == S_EXECUTE) begin
      if (is_alu) begin
        wr_en = 1'b1;
      end else if (opcode == OP_LDI) begin
        wr_en   = 1'b1;
        wr_data = DATA_W'(imm);
      end
    end else if (state_reg == S_MEM) begin
      wr_en   = 1'b1;
      wr_data = dmem_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    completing = 1'b0;
    case (state_reg)
      S_FETCH:   state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (opcode == OP_LD)        state_next = S_MEM;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else                        completing = 1'b1;
      end
      S_MEM:     completing = 1'b1;
      S_HALT:    state_next = S_HALT;
      S_WAIT:    if (step_req) state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
    // step_mode is only looked at on the instruction's last cycle
    if (completing) state_next = step_mode ? S_WAIT : S_FETCH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        ir_reg <= imem_rdata;
        pc_reg <= pc_reg + 1'b1;
      end
      if (state_reg == S_EXECUTE) begin
        if (is_alu)    z_reg  <= (alu_res == '0);
        if (take_jump) pc_reg <= PC_W'(imm);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rd == 2'(i)) regs[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Bench for mini_cpu_core: directed programs plus random programs checked against
// an instruction-level model; a second narrow-pc/wide-data instance checks wrap.
module tb_mini_cpu_core;
  localparam int PCN = 256;
  localparam int DMASK = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, step_mode, step_req;
  logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_dbg;
  logic [15:0] imem_rdata, ir_dbg;
  logic        dmem_we, halted, retired;
  logic [2:0]  state_dbg;

  mini_cpu_core #(.PC_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .step_mode(step_mode), .step_req(step_req),
    .state_dbg(state_dbg), .pc_dbg(pc_dbg), .ir_dbg(ir_dbg), .halted(halted),
    .retired(retired)
  );

  logic        reset_w_n;
  logic [3:0]  imem_addr_w, pc_dbg_w;
  logic [15:0] imem_rdata_w, ir_dbg_w, dmem_wdata_w, dmem_rdata_w;
  logic [7:0]  dmem_addr_w;
  logic        dmem_we_w, halted_w, retired_w;
  logic [2:0]  state_dbg_w;

  mini_cpu_core #(.PC_W(4), .DATA_W(16), .RESET_PC(4'hC)) dutw (
    .clk(clk), .reset_n(reset_w_n), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .dmem_addr(dmem_addr_w), .dmem_wdata(dmem_wdata_w), .dmem_we(dmem_we_w),
    .dmem_rdata(dmem_rdata_w), .step_mode(1'b0), .step_req(1'b0),
    .state_dbg(state_dbg_w), .pc_dbg(pc_dbg_w), .ir_dbg(ir_dbg_w), .halted(halted_w),
    .retired(retired_w)
  );

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [15:0] imem_w [16];
  logic [15:0] dmem_w [256];
  int we_count = 0;

  always @(posedge clk) begin
    imem_rdata   <= imem[imem_addr];
    dmem_rdata   <= dmem[dmem_addr];
    imem_rdata_w <= imem_w[imem_addr_w];
    dmem_rdata_w <= dmem_w[dmem_addr_w];
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      we_count <= we_count + 1;
    end
    if (dmem_we_w) dmem_w[dmem_addr_w] <= dmem_wdata_w;
  end

  // instruction-level reference state
  int unsigned m_r [4];
  bit          m_z;
  int unsigned m_pc;
  logic [7:0]  m_mem [256];

  int n_checks = 0;
  int n_pass = 0;
  bit stop;
  int we0, cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_z = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    reset_n = 1'b0;
    step_req = 1'b0;
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_pc", pc_dbg, 0);
    check("rst_ir", ir_dbg, 0);
    check("rst_halted", halted, 0);
    check("rst_retired", retired, 0);
    check("rst_we", dmem_we, 0);
    repeat (cyc) @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  // Runs one instruction from its FETCH cycle to the cycle after it retires.
  task automatic run_instr(input bit poke, output bit halt_seen);
    logic [15:0] ins;
    int op, rd, rs, imm, exp_cyc, n;
    int unsigned res, exp_wd;
    bit exp_we;
    check("fetch_state", state_dbg, 0);
    check("fetch_addr", imem_addr, m_pc);
    ins = imem[m_pc];
    op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    m_pc = (m_pc + 1) % PCN;
    exp_cyc = 3; exp_we = 1'b0; exp_wd = 0; halt_seen = 1'b0;
    case (op)
      1: m_r[rd] = imm;
      2, 3, 4, 5: begin
        if (op == 2)      res = (m_r[rd] + m_r[rs]) & DMASK;
        else if (op == 3) res = (m_r[rd] - m_r[rs]) & DMASK;
        else if (op == 4) res = m_r[rd] & m_r[rs];
        else              res = m_r[rd] | m_r[rs];
        m_r[rd] = res;
        m_z = (res == 0);
      end
      6: begin m_r[rd] = m_mem[imm]; exp_cyc = 4; end
      7: begin exp_we = 1'b1; exp_wd = m_r[rd]; m_mem[imm] = 8'(m_r[rd]); end
      8: m_pc = imm % PCN;
      9: if (m_z) m_pc = imm % PCN;
      10: halt_seen = 1'b1;
      default: ;
    endcase
    n = 1;
    while (!retired && n < 6) begin
      @(negedge clk);
      n++;
      step_req = poke && (n == 2);
    end
    check("cycles", n, exp_cyc);
    check("ir", ir_dbg, ins);
    check("we", dmem_we, exp_we);
    if (exp_we) begin
      check("st_addr", dmem_addr, imm);
      check("st_data", dmem_wdata, exp_wd);
    end
    if (op == 6) check("ld_mem_state", state_dbg, 3);
    @(negedge clk);
    check("pc", pc_dbg, m_pc);
    check("retired_pulse", retired, 0);
    check("post_state", state_dbg, halt_seen ? 4 : (step_mode ? 5 : 0));
    check("halted", halted, halt_seen);
  endtask

  task automatic release_step(input int idle);
    repeat (idle) @(negedge clk);
    check("wait_state", state_dbg, 5);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    check("step_fetch", state_dbg, 0);
  endtask

  task automatic wide_instr(input string tag, input logic [15:0] exp_ir, input logic [3:0] exp_pc,
                            input bit st, input logic [15:0] wd);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_retired"}, retired_w, 1);
    check({tag, "_ir"}, ir_dbg_w, exp_ir);
    check({tag, "_we"}, dmem_we_w, st);
    if (st) check({tag, "_wdata"}, dmem_wdata_w, wd);
    @(negedge clk);
    check({tag, "_pc"}, pc_dbg_w, exp_pc);
  endtask

  function automatic logic [15:0] rand_ins();
    int op, imm;
    op = $urandom_range(0, 15);
    if (op == 10 && $urandom_range(0, 7) != 0) op = 7;
    if (op == 6 || op == 7)      imm = $urandom_range(0, 15);
    else if (op == 8 || op == 9) imm = $urandom_range(0, 40);
    else                         imm = $urandom_range(0, 255);
    return {4'(op), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'(imm)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; reset_w_n = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    for (int a = 0; a < 256; a++) begin
      dmem[a] = 8'($urandom);
      m_mem[a] = dmem[a];
      dmem_w[a] = 16'h0;
    end

    // reset, LDI, ADD, HALT timing
    clear_prog();
    imem[0] = 16'h1405; imem[1] = 16'h1803; imem[2] = 16'h2600; imem[3] = 16'hA000;
    do_reset(2);
    for (int i = 0; i < 4; i++) run_instr(1'b0, stop);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_hold", halted, 1);
      check("halt_pc", pc_dbg, 8'h04);
    end

    // same sum made observable through a store, then a not-taken JZ
    imem[3] = 16'h7440; imem[4] = 16'h9000; imem[5] = 16'hA000;
    do_reset(1);
    stop = 1'b0;
    for (int i = 0; i < 8 && !stop; i++) run_instr(1'b0, stop);
    check("sum_mem", dmem[8'h40], 8'h08);

    // flags and branch, taken then not taken
    clear_prog();
    imem[0] = 16'h1007; imem[1] = 16'h1407; imem[2] = 16'h3100; imem[3] = 16'h9010;
    do_reset(1);
    for (int i = 0; i < 4; i++) run_instr(1'b0, stop);
    check("jz_taken_pc", pc_dbg, 8'h10);
    imem[1] = 16'h1406;
    do_reset(1);
    for (int i = 0; i < 4; i++) run_instr(1'b0, stop);
    check("jz_not_taken_pc", pc_dbg, 8'h04);

    // load / store
    clear_prog();
    imem[0] = 16'h1CA5; imem[1] = 16'h7C20; imem[2] = 16'h6820; imem[3] = 16'h7821; imem[4] = 16'hA000;
    do_reset(1);
    we0 = we_count;
    for (int i = 0; i < 3; i++) run_instr(1'b0, stop);
    check("st_pulse_count", we_count - we0, 1);
    check("st_mem", dmem[8'h20], 8'hA5);
    for (int i = 0; i < 2; i++) run_instr(1'b0, stop);
    check("ld_copy_mem", dmem[8'h21], 8'hA5);

    // single step
    clear_prog();
    imem[0] = 16'h1001; imem[1] = 16'h1002; imem[2] = 16'h7030; imem[3] = 16'hA000;
    step_mode = 1'b1;
    do_reset(1);
    run_instr(1'b0, stop);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (state_dbg != 3'd5) cnt++;
    end
    check("idle_no_fetch", cnt, 0);
    release_step(0);
    run_instr(1'b1, stop);
    release_step(3);
    step_mode = 1'b0;
    run_instr(1'b0, stop);
    run_instr(1'b0, stop);

    // reset during a store's EXECUTE cycle
    clear_prog();
    imem[0] = 16'h1477; imem[1] = 16'h7450;
    dmem[8'h50] = 8'h3C; m_mem[8'h50] = 8'h3C;
    do_reset(1);
    run_instr(1'b0, stop);
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_we", dmem_we, 1);
    we0 = we_count;
    #2 reset_n = 1'b0;
    #1;
    check("abort_we", dmem_we, 0);
    check("abort_state", state_dbg, 0);
    check("abort_pc", pc_dbg, 0);
    check("abort_ir", ir_dbg, 0);
    check("abort_retired", retired, 0);
    check("abort_halted", halted, 0);
    @(negedge clk);
    check("abort_no_write", we_count - we0, 0);
    check("abort_mem", dmem[8'h50], 8'h3C);
    model_reset();
    reset_n = 1'b1;
    check("restart_addr", imem_addr, 8'h00);
    run_instr(1'b0, stop);
    run_instr(1'b0, stop);

    // random programs with random single-stepping
    for (int p = 0; p < 6; p++) begin
      clear_prog();
      for (int a = 0; a < 32; a++) imem[a] = rand_ins();
      step_mode = 1'b0;
      do_reset(1);
      for (int k = 0; k < 40; k++) begin
        step_mode = ($urandom_range(0, 3) == 0);
        run_instr($urandom_range(0, 1) == 1, stop);
        if (stop) break;
        if (step_mode) release_step($urandom_range(0, 3));
      end
    end
    step_mode = 1'b0;

    // narrow pc / wide data instance: jump truncation, pc wrap, 16-bit wrap
    for (int a = 0; a < 16; a++) imem_w[a] = 16'h0000;
    imem_w[4'hC] = 16'h1000; imem_w[4'hD] = 16'h1401; imem_w[4'hE] = 16'h80FF;
    imem_w[4'hF] = 16'h3100; imem_w[4'h0] = 16'h7010; imem_w[4'h1] = 16'h2100;
    imem_w[4'h2] = 16'h9009; imem_w[4'h9] = 16'h7011; imem_w[4'hA] = 16'hA000;
    @(negedge clk);
    reset_w_n = 1'b1;
    check("w_start_addr", imem_addr_w, 4'hC);
    check("w_start_state", state_dbg_w, 0);
    wide_instr("w_ldi0", 16'h1000, 4'hD, 1'b0, 16'h0);
    wide_instr("w_ldi1", 16'h1401, 4'hE, 1'b0, 16'h0);
    wide_instr("w_jmp", 16'h80FF, 4'hF, 1'b0, 16'h0);
    wide_instr("w_sub", 16'h3100, 4'h0, 1'b0, 16'h0);
    wide_instr("w_st_ones", 16'h7010, 4'h1, 1'b1, 16'hFFFF);
    wide_instr("w_add", 16'h2100, 4'h2, 1'b0, 16'h0);
    wide_instr("w_jz", 16'h9009, 4'h9, 1'b0, 16'h0);
    wide_instr("w_st_zero", 16'h7011, 4'hA, 1'b1, 16'h0000);
    wide_instr("w_halt", 16'hA000, 4'hB, 1'b0, 16'h0);
    check("w_halted", halted_w, 1);
    check("w_halt_state", state_dbg_w, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
